// File: rtl/bsg_mem_seg_arb_pkg.sv
// Shared types and helpers for the arbitrated segmented bit-masked-write SRAM front end.
package bsg_mem_seg_arb_pkg;

  typedef enum logic {
    eInit,
    eRun
  } state_e;

  // Upper bounds for the segment-to-bit expansion helper; callers cast the result down.
  localparam int max_width_lp        = 256;
  localparam int max_segments_lp     = 32;
  localparam int seg_idx_width_lp    = $clog2(max_segments_lp);

  function automatic logic [max_width_lp-1:0] seg_to_bit_mask(
    input logic [max_segments_lp-1:0] seg_v,
    input int                         seg_width
  );
    logic [max_width_lp-1:0]     mask;
    logic [seg_idx_width_lp-1:0] seg_idx;
    mask    = '0;
    seg_idx = '0;
    for (int i = 0; i < max_width_lp; i++) begin
      if (seg_width > 0 && (i / seg_width) < max_segments_lp) begin
        seg_idx = seg_idx_width_lp'(i / seg_width);
        mask[i] = seg_v[seg_idx];
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/bsg_mem_seg_rr_arb.sv
// Round-robin arbiter: searches cyclically from the requester after the last winner.
module bsg_mem_seg_rr_arb
  import bsg_mem_seg_arb_pkg::*;
#(
  parameter  int num_req_p   = 2,
  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   en_i,
  input  logic [num_req_p-1:0]   reqs_i,
  output logic [num_req_p-1:0]   grants_o,
  output logic [id_width_lp-1:0] grant_id_o
);

  logic [id_width_lp-1:0] last_q, last_d;
  logic [id_width_lp-1:0] idx;
  logic                   found;

  always_comb begin
    grants_o   = '0;
    grant_id_o = '0;
    idx        = '0;
    found      = 1'b0;
    for (int i = 1; i <= num_req_p; i++) begin
      idx = id_width_lp'((int'(last_q) + i) % num_req_p);
      if (en_i && !found && reqs_i[idx]) begin
        found         = 1'b1;
        grants_o[idx] = 1'b1;
        grant_id_o    = idx;
      end
    end
    last_d = found ? grant_id_o : last_q;
  end

  // Reset points at the last requester so requester 0 wins first.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_q <= id_width_lp'(num_req_p - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_segmented_arb.sv
// Shares one segmented 1RW bit-masked SRAM among num_req_p valid/ready requesters,
// with an optional post-reset clear and one-cycle-latency read responses.
module bsg_mem_1rw_sync_mask_write_bit_segmented_arb
  import bsg_mem_seg_arb_pkg::*;
#(
  parameter  int width_p          = 32,
  parameter  int els_p            = 64,
  parameter  int num_segments_p   = 4,
  parameter  int num_req_p        = 2,
  parameter  int init_zero_p      = 1,
  localparam int lg_els_lp        = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int segment_width_lp = width_p / num_segments_p,
  localparam int id_width_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic [num_req_p-1:0]                      v_i,
  input  logic [num_req_p-1:0]                      w_i,
  input  logic [num_req_p-1:0][lg_els_lp-1:0]       addr_i,
  input  logic [num_req_p-1:0][width_p-1:0]         data_i,
  input  logic [num_req_p-1:0][width_p-1:0]         w_mask_i,
  input  logic [num_req_p-1:0][num_segments_p-1:0]  seg_v_i,
  output logic [num_req_p-1:0]                      ready_o,
  output logic [num_req_p-1:0]                      v_o,
  output logic [width_p-1:0]                        data_o,
  output logic                                      init_done_o,
  output logic [num_segments_p-1:0]                 mem_v_o,
  output logic                                      mem_w_o,
  output logic [lg_els_lp-1:0]                      mem_addr_o,
  output logic [width_p-1:0]                        mem_data_o,
  output logic [width_p-1:0]                        mem_w_mask_o,
  input  logic [width_p-1:0]                        mem_data_i
);

  localparam state_e reset_state_lp = (init_zero_p != 0) ? eInit : eRun;

  // Handshake: a request on port k is accepted in the cycle v_i[k] & ready_o[k]
  // is high; ready_o is one-hot and depends only on v_i and the arbiter pointer.
  // Read responses (v_o) are one-cycle pulses with no backpressure.

  state_e                      state_q, state_d;
  logic [lg_els_lp-1:0]        cnt_q, cnt_d;
  logic [num_req_p-1:0]        resp_v_q, resp_v_d;
  logic [num_segments_p-1:0]   resp_seg_q, resp_seg_d;
  logic                        run_en;
  logic [num_req_p-1:0]        grants;
  logic [id_width_lp-1:0]      grant_id;
  logic                        granted;
  logic [width_p-1:0]          resp_mask;

  // Gating with reset_n_i keeps ready_o and the memory strobes low while reset is held.
  assign run_en  = reset_n_i & (state_q == eRun);
  assign granted = |grants;

  bsg_mem_seg_rr_arb #(
    .num_req_p(num_req_p)
  ) arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (run_en),
    .reqs_i    (v_i),
    .grants_o  (grants),
    .grant_id_o(grant_id)
  );

  assign ready_o     = grants;
  assign init_done_o = (state_q == eRun);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == eInit) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == lg_els_lp'(els_p - 1)) begin
        state_d = eRun;
      end
    end
  end

  always_comb begin
    mem_v_o      = '0;
    mem_w_o      = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    mem_w_mask_o = '0;
    if (reset_n_i) begin
      if (state_q == eInit) begin
        mem_v_o      = '1;
        mem_w_o      = 1'b1;
        mem_addr_o   = cnt_q;
        mem_w_mask_o = '1;
      end else if (granted) begin
        mem_v_o      = seg_v_i[grant_id];
        mem_w_o      = w_i[grant_id];
        mem_addr_o   = addr_i[grant_id];
        mem_data_o   = data_i[grant_id];
        mem_w_mask_o = w_mask_i[grant_id];
      end
    end
  end

  // A read with no segments still completes and returns an all-zero response.
  always_comb begin
    resp_v_d   = '0;
    resp_seg_d = resp_seg_q;
    if (granted && !w_i[grant_id]) begin
      resp_v_d   = grants;
      resp_seg_d = seg_v_i[grant_id];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= reset_state_lp;
      cnt_q      <= '0;
      resp_v_q   <= '0;
      resp_seg_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      resp_v_q   <= resp_v_d;
      resp_seg_q <= resp_seg_d;
    end
  end

  assign resp_mask = width_p'(seg_to_bit_mask(max_segments_lp'(resp_seg_q), segment_width_lp));
  assign v_o       = resp_v_q;
  assign data_o    = (|resp_v_q) ? (mem_data_i & resp_mask) : '0;

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_segmented_arb.sv
// Bench for the arbitrated segmented SRAM front end with a behavioural SRAM and reference memory.
module tb_bsg_mem_1rw_sync_mask_write_bit_segmented_arb;

  localparam int W    = 32;
  localparam int ELS  = 4;
  localparam int SEGS = 4;
  localparam int N    = 2;
  localparam int LG   = 2;

  logic                       clk;
  logic                       reset_n;
  logic [N-1:0]               v_i, w_i;
  logic [N-1:0][LG-1:0]       addr_i;
  logic [N-1:0][W-1:0]        data_i, w_mask_i;
  logic [N-1:0][SEGS-1:0]     seg_v_i;
  logic [N-1:0]               ready_o, v_o;
  logic [W-1:0]               data_o;
  logic                       init_done_o;
  logic [SEGS-1:0]            mem_v_o;
  logic                       mem_w_o;
  logic [LG-1:0]              mem_addr_o;
  logic [W-1:0]               mem_data_o, mem_w_mask_o, mem_data_i;

  logic [W-1:0] sram    [ELS];
  logic [W-1:0] ref_mem [ELS];
  logic [33:0]  exp_q[$];
  logic [33:0]  mon_e;
  int           tb_last;
  int           n_checks = 0;
  int           n_errors = 0;

  bsg_mem_1rw_sync_mask_write_bit_segmented_arb #(
    .width_p(W), .els_p(ELS), .num_segments_p(SEGS), .num_req_p(N), .init_zero_p(1)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
    .data_i(data_i), .w_mask_i(w_mask_i), .seg_v_i(seg_v_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .init_done_o(init_done_o), .mem_v_o(mem_v_o),
    .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] segexp(input logic [SEGS-1:0] s);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) r[b] = s[2'(b / 8)];
    return r;
  endfunction

  // Behavioural segmented SRAM; unread segments return garbage.
  always @(posedge clk) begin
    for (int s = 0; s < SEGS; s++) begin
      if (mem_v_o[s]) begin
        if (mem_w_o) begin
          for (int b = s * 8; b < s * 8 + 8; b++)
            if (mem_w_mask_o[b]) sram[mem_addr_o][b] = mem_data_o[b];
        end else begin
          mem_data_i[s*8 +: 8] <= sram[mem_addr_o][s*8 +: 8];
        end
      end else begin
        mem_data_i[s*8 +: 8] <= 8'($urandom);
      end
    end
  end

  // scoreboard monitor: each queued read must answer exactly one cycle later
  always @(negedge clk) begin
    if (reset_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_eq("resp_v", 64'(v_o), 64'(2'b01 << mon_e[33:32]));
      check_eq("resp_data", 64'(data_o), 64'(mon_e[31:0]));
    end else if (reset_n) begin
      check_eq("resp_idle", 64'(v_o), 64'(0));
    end
  end

  // driver tasks
  task automatic set_req(input int k, input logic v, input logic w, input logic [LG-1:0] a,
                         input logic [W-1:0] d, input logic [W-1:0] m, input logic [SEGS-1:0] s);
    v_i[1'(k)]      = v;
    w_i[1'(k)]      = w;
    addr_i[1'(k)]   = a;
    data_i[1'(k)]   = d;
    w_mask_i[1'(k)] = m;
    seg_v_i[1'(k)]  = s;
  endtask

  task automatic do_reset();
    v_i     = 2'b11;
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("rst_ready", 64'(ready_o), 64'(0));
    check_eq("rst_v_o", 64'(v_o), 64'(0));
    check_eq("rst_data_o", 64'(data_o), 64'(0));
    check_eq("rst_mem_v", 64'(mem_v_o), 64'(0));
    check_eq("rst_mem_w", 64'(mem_w_o), 64'(0));
    check_eq("rst_init_done", 64'(init_done_o), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    tb_last = N - 1;
    for (int i = 0; i < ELS; i++) ref_mem[i] = '0;
  endtask

  task automatic check_init_seq(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("init_done_low", 64'(init_done_o), 64'(0));
      check_eq("init_ready", 64'(ready_o), 64'(0));
      check_eq("init_mem_v", 64'(mem_v_o), 64'(4'hf));
      check_eq("init_mem_w", 64'(mem_w_o), 64'(1));
      check_eq("init_addr", 64'(mem_addr_o), 64'(i));
      check_eq("init_data", 64'(mem_data_o), 64'(0));
      check_eq("init_mask", 64'(mem_w_mask_o), 64'(32'hffffffff));
      @(posedge clk); #1;
    end
  endtask

  task automatic check_done();
    v_i = '0;
    @(negedge clk);
    check_eq("init_done_high", 64'(init_done_o), 64'(1));
    check_eq("idle_ready", 64'(ready_o), 64'(0));
    @(posedge clk); #1;
  endtask

  // One run cycle: predict the grant, check memory port, update the reference, push reads.
  task automatic step();
    logic [N-1:0] exp_g;
    int           gid;
    logic         g;
    logic [W-1:0] m;
    @(negedge clk); #1;
    exp_g = '0;
    gid   = -1;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (tb_last + i) % N;
      if (gid < 0 && v_i[1'(k)]) gid = k;
    end
    if (gid >= 0) exp_g[1'(gid)] = 1'b1;
    check_eq("ready", 64'(ready_o), 64'(exp_g));
    if (gid >= 0) begin
      g = 1'(gid);
      check_eq("mem_v", 64'(mem_v_o), 64'(seg_v_i[g]));
      if (seg_v_i[g] != '0) begin
        check_eq("mem_w", 64'(mem_w_o), 64'(w_i[g]));
        check_eq("mem_addr", 64'(mem_addr_o), 64'(addr_i[g]));
      end
      m = segexp(seg_v_i[g]);
      if (w_i[g]) begin
        ref_mem[addr_i[g]] = (ref_mem[addr_i[g]] & ~(w_mask_i[g] & m)) | (data_i[g] & w_mask_i[g] & m);
      end else begin
        exp_q.push_back({2'(gid), ref_mem[addr_i[g]] & m});
      end
      tb_last = gid;
    end else begin
      check_eq("mem_v_idle", 64'(mem_v_o), 64'(0));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    v_i = '0; w_i = '0; addr_i = '0; data_i = '0; w_mask_i = '0; seg_v_i = '0;
    mem_data_i = '0;
    tb_last = N - 1;
    for (int i = 0; i < ELS; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;

    // clear sequence after reset
    do_reset();
    check_init_seq(ELS);
    check_done();

    // reset during the clear restarts it at address 0
    for (int i = 0; i < ELS; i++) sram[i] = $urandom;
    do_reset();
    check_init_seq(2);
    do_reset();
    check_init_seq(ELS);
    check_done();

    // write then read with a partial segment set
    set_req(0, 1, 1, 2'd2, 32'hdeadbeef, 32'hffffffff, 4'b1111);
    set_req(1, 0, 0, 2'd0, 32'h0, 32'h0, 4'b0000);
    step();
    set_req(0, 1, 0, 2'd2, 32'h0, 32'h0, 4'b0101);
    step();
    set_req(0, 0, 0, 2'd0, 32'h0, 32'h0, 4'b0000);
    step();

    // bit-masked write
    set_req(0, 1, 1, 2'd3, 32'hffffffff, 32'habcdef11, 4'b1111);
    step();
    set_req(0, 1, 0, 2'd3, 32'h0, 32'h0, 4'b1111);
    step();

    // read with no segments: handshake completes, zero response
    set_req(0, 1, 0, 2'd1, 32'h0, 32'h0, 4'b0000);
    step();
    set_req(0, 0, 0, 2'd0, 32'h0, 32'h0, 4'b0000);
    step();

    // both requesters continuously reading addr 1
    set_req(0, 1, 0, 2'd1, 32'h0, 32'h0, 4'b1111);
    set_req(1, 1, 0, 2'd1, 32'h0, 32'h0, 4'b1111);
    repeat (4) step();

    // random traffic
    for (int c = 0; c < 80; c++) begin
      for (int k = 0; k < N; k++) begin
        set_req(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                $urandom, ($urandom_range(0, 1) != 0) ? 32'hffffffff : $urandom,
                4'($urandom_range(0, 15)));
      end
      step();
    end
    v_i = '0;
    repeat (2) step();
    check_eq("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bsg_mem_1rw_sync_mask_write_bit_segmented_arb.md
Name: bsg_mem_1rw_sync_mask_write_bit_segmented_arb

Overview:
- Shares one segmented 1-port synchronous bit-masked-write SRAM among num_req_p requesters.
- Arbitration is round-robin, one access per cycle; each requester uses a valid/ready handshake.
- Read responses are returned one cycle later, with unaccessed segments zeroed.
- An optional post-reset clear FSM writes zero to every word before requests are accepted.
- Sits between client pipelines and the segmented SRAM instance; drives all of its ports.

Parameters:
width_p, 32, total data width in bits (multiple of num_segments_p)
els_p, 64, SRAM depth in words
num_segments_p, 4, independently enabled segments; segment_width_lp = width_p/num_segments_p
num_req_p, 2, number of requesters (>=1)
init_zero_p, 1, 1 = clear all words after reset; 0 = accept requests immediately
lg_els_lp, localparam, `BSG_SAFE_CLOG2(els_p)

Ports:
clk_i  in  1  single clock; all state on posedge
reset_n_i  in  1  asynchronous, active-low reset
v_i  in  num_req_p  request valid per requester
w_i  in  num_req_p  1 = write, 0 = read
addr_i  in  num_req_p x lg_els_lp  word address
data_i  in  num_req_p x width_p  write data
w_mask_i  in  num_req_p x width_p  per-bit write mask (1 = write bit)
seg_v_i  in  num_req_p x num_segments_p  segments touched by the request
ready_o  out  num_req_p  one-hot grant; handshake = v_i[k] & ready_o[k]
v_o  out  num_req_p  one-hot read-response valid
data_o  out  width_p  read response data
init_done_o  out  1  high once the clear is complete
mem_v_o  out  num_segments_p  SRAM per-segment valid
mem_w_o  out  1  SRAM write enable
mem_addr_o  out  lg_els_lp  SRAM address
mem_data_o  out  width_p  SRAM write data
mem_w_mask_o  out  width_p  SRAM bit mask
mem_data_i  in  width_p  SRAM read data, valid the cycle after a read

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - ready_o=0, v_o=0, data_o=0, mem_v_o=0, mem_w_o=0.
  - Init counter=0.
  - Round-robin pointer last_r=num_req_p-1, so requester 0 has first priority.
  - State=eInit if init_zero_p, else eRun.
  - init_done_o=~init_zero_p.
- FSM eInit:
  - Each cycle: mem_v_o=all 1s, mem_w_o=1, mem_addr_o=cnt_r, mem_data_o=0, mem_w_mask_o=all 1s; ready_o=0.
  - cnt_r increments each cycle. When cnt_r==els_p-1, the next state is eRun and init_done_o=1 from the next cycle.
  - Exactly els_p write cycles.
  - Reset asserted mid-init restarts the clear at address 0.
- FSM eRun:
  - Grant g = first k with v_i[k], searching cyclically from last_r+1. ready_o=onehot(g), or 0 if no requests.
  - ready_o depends combinationally on v_i and last_r only. It is independent of data/addr.
  - On grant, mem_v_o=seg_v_i[g], mem_w_o=w_i[g], and addr/data/mask are taken from requester g; last_r<=g.
  - No grant: mem_v_o=0; the other memory outputs are don't-care.
  - eRun is never left except by reset.
- Read response:
  - Granted read at cycle t registers g and seg_v_i[g]. At t+1, v_o=onehot(g).
  - At t+1, data_o = mem_data_i with every segment whose registered seg bit is 0 forced to 0.
  - v_o is a single-cycle pulse with no backpressure; requesters must sink it.
  - A granted write produces no response.
- Granted request with seg_v_i=0:
  - The handshake completes and mem_v_o=0.
  - A read still returns v_o at t+1 with data_o=0.
- Ordering: a write at t followed by a read of the same address at t+1 returns the written bits; no bypass logic.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,num_req_p-1,0,...
- num_req_p=1: the arbiter degenerates to pass-through; ready_o=v_i in eRun.

Decomposition:
- Package bsg_mem_seg_arb_pkg:
  - state enum {eInit, eRun}.
  - Helper function for the segment-to-bit mask expansion (segment_width_lp replication).
- Sub-module bsg_mem_seg_rr_arb:
  - Owns last_r and the cyclic priority search.
  - Ports: clk_i, reset_n_i, en_i, reqs_i, grants_o, grant_id_o.
  - en_i is gated low in eInit.
- The top holds the FSM, init counter, response registers and memory muxing.

Test Plan:
1. els_p=4, init_zero_p=1: release reset -> exactly 4 cycles mem_w_o=1, addr 0,1,2,3, data 0; init_done_o rises on cycle 5; ready_o=0 throughout.
2. After init, req0 writes addr 2 data 32'hdeadbeef, mask all 1s, seg_v 4'b1111; next cycle it reads addr 2 with seg_v 4'b0101 -> v_o=2'b01 one cycle later, data_o=32'h00ad00ef.
3. Both requesters valid continuously, reads of addr 1 -> ready_o sequence 01,10,01,10; each v_o pulse follows its grant by 1 cycle.
4. Write addr 3 data 32'hffffffff with mask 32'habcdef11 after init -> a read of addr 3 returns 32'habcdef11.
5. Assert reset_n_i low for 1 cycle at init cycle 2 -> the clear restarts at addr 0 and completes all 4 writes; no ready_o before init_done_o.
6. Granted read with seg_v_i=0 -> mem_v_o=0 that cycle; v_o pulses next cycle with data_o=0.
